// File: rtl/video_pixel_op_if.sv
// Video stream bundle for video_pixel_op: raw pixel/sync/control in, processed pixel/sync and status out.
// The slave modport is the operator's view, the master modport the driving stage's view.
interface video_pixel_op_if #(
    parameter int CH  = 3,
    parameter int BPC = 8
);
    logic [1:0]        mode_in;
    logic [CH-1:0]     chan_en;
    logic [BPC-1:0]    thresh_in;
    logic              activeVideo;
    logic [CH*BPC-1:0] videoData;
    logic              vsync;
    logic              hsync;
    logic              activeVideo_out;
    logic [CH*BPC-1:0] videoData_out;
    logic              vsync_out;
    logic              hsync_out;
    logic [1:0]        mode_active;
    logic [15:0]       frame_count;
    logic [23:0]       pixel_count;

    modport slave (
        input  mode_in, chan_en, thresh_in, activeVideo, videoData, vsync, hsync,
        output activeVideo_out, videoData_out, vsync_out, hsync_out,
        output mode_active, frame_count, pixel_count
    );

    modport master (
        output mode_in, chan_en, thresh_in, activeVideo, videoData, vsync, hsync,
        input  activeVideo_out, videoData_out, vsync_out, hsync_out,
        input  mode_active, frame_count, pixel_count
    );
endinterface

// File: rtl/video_pixel_op.sv
// Per-pixel operator (pass/invert/threshold/grayscale) with frame-synchronous control shadows and a LAT-deep aligned pipeline.
// Optional frame/pixel statistics are built only when VIDEO_PIXOP_STATS_EN is defined.
module video_pixel_op #(
    parameter int CH  = 3,
    parameter int BPC = 8,
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    video_pixel_op_if.slave vid
);
    localparam int             PW      = CH * BPC;
    localparam bit             GRAY_OK = (CH == 3);
    localparam logic [BPC-1:0] THR_RST = {1'b1, {(BPC-1){1'b0}}};

    logic             vsync_q_r;
    logic             frame_start_s;
    logic [1:0]       mode_sh_r;
    logic [CH-1:0]    en_sh_r;
    logic [BPC-1:0]   thr_sh_r;
    logic [BPC-1:0]   gray_s;
    logic [BPC-1:0]   ch_s;
    logic [PW-1:0]    stage1_s;
    logic [PW-1:0]    pix_r [LAT];
    logic             av_r  [LAT];
    logic             vs_r  [LAT];
    logic             hs_r  [LAT];

    assign frame_start_s = vid.vsync & ~vsync_q_r;

    // Luma-style weighted mean; the sum is two bits wider than a channel so it can never overflow.
    generate
        if (GRAY_OK) begin : g_gray
            assign gray_s = BPC'(({2'b00, vid.videoData[0 +: BPC]}
                                + {1'b0, vid.videoData[BPC +: BPC], 1'b0}
                                + {2'b00, vid.videoData[2*BPC +: BPC]}) >> 2);
        end else begin : g_no_gray
            assign gray_s = '0;
        end
    endgenerate

    // Control shadows: reloaded only on a vsync rise so a frame is never processed with mixed settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q_r <= 1'b0;
            mode_sh_r <= 2'b00;
            en_sh_r   <= '1;
            thr_sh_r  <= THR_RST;
        end else begin
            vsync_q_r <= vid.vsync;
            if (frame_start_s) begin
                mode_sh_r <= vid.mode_in;
                en_sh_r   <= vid.chan_en;
                thr_sh_r  <= vid.thresh_in;
            end
        end
    end

    // Stage-1 pixel operation, using the shadows as they stood before this cycle's edge.
    always_comb begin
        stage1_s = '0;
        ch_s     = '0;
        for (int c = 0; c < CH; c++) begin
            ch_s = vid.videoData[c*BPC +: BPC];
            if (!vid.activeVideo) begin
                stage1_s[c*BPC +: BPC] = '0;
            end else if (en_sh_r[c]) begin
                case (mode_sh_r)
                    2'b00:   stage1_s[c*BPC +: BPC] = ch_s;
                    2'b01:   stage1_s[c*BPC +: BPC] = ~ch_s;
                    2'b10:   stage1_s[c*BPC +: BPC] = (ch_s >= thr_sh_r) ? '1 : '0;
                    2'b11: begin
                        if (GRAY_OK) begin
                            stage1_s[c*BPC +: BPC] = gray_s;
                        end else begin
                            stage1_s[c*BPC +: BPC] = ch_s;
                        end
                    end
                    default: stage1_s[c*BPC +: BPC] = ch_s;
                endcase
            end else begin
                stage1_s[c*BPC +: BPC] = ch_s;
            end
        end
    end

    // Matched delay line: pixel and all timing signals travel together through LAT registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pix_r[i] <= '0;
                av_r[i]  <= 1'b0;
                vs_r[i]  <= 1'b0;
                hs_r[i]  <= 1'b0;
            end
        end else begin
            pix_r[0] <= stage1_s;
            av_r[0]  <= vid.activeVideo;
            vs_r[0]  <= vid.vsync;
            hs_r[0]  <= vid.hsync;
            for (int i = 1; i < LAT; i++) begin
                pix_r[i] <= pix_r[i-1];
                av_r[i]  <= av_r[i-1];
                vs_r[i]  <= vs_r[i-1];
                hs_r[i]  <= hs_r[i-1];
            end
        end
    end

    assign vid.videoData_out   = pix_r[LAT-1];
    assign vid.activeVideo_out = av_r[LAT-1];
    assign vid.vsync_out       = vs_r[LAT-1];
    assign vid.hsync_out       = hs_r[LAT-1];
    assign vid.mode_active     = mode_sh_r;

`ifdef VIDEO_PIXOP_STATS_EN
    logic [15:0] frame_cnt_r;
    logic [23:0] acc_r;
    logic [23:0] pix_cnt_r;
    logic [23:0] acc_inc_s;

    // Saturating active-pixel accumulator including the current input cycle.
    always_comb begin
        if (vid.activeVideo && (acc_r != 24'hFF_FFFF)) begin
            acc_inc_s = acc_r + 24'd1;
        end else begin
            acc_inc_s = acc_r;
        end
    end

    // Frame statistics: latch the finished frame's pixel total and restart on each boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'h0000;
            acc_r       <= 24'h00_0000;
            pix_cnt_r   <= 24'h00_0000;
        end else if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
            pix_cnt_r   <= acc_inc_s;
            acc_r       <= 24'h00_0000;
        end else begin
            acc_r       <= acc_inc_s;
        end
    end

    assign vid.frame_count = frame_cnt_r;
    assign vid.pixel_count = pix_cnt_r;
`else
    assign vid.frame_count = 16'h0000;
    assign vid.pixel_count = 24'h00_0000;
`endif
endmodule

// File: tb/tb_video_pixel_op.sv
// Directed self-checking bench for video_pixel_op (CH=3, BPC=8, LAT=2); statistics are checked when
// VIDEO_PIXOP_STATS_EN is defined and checked as tied to zero otherwise.
module tb_video_pixel_op;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;
    int   exp_frames;

    string       tag_d1;
    logic [23:0] exp_d1;
    bit          chk_d1;

    video_pixel_op_if #(.CH(3), .BPC(8)) vif ();

    video_pixel_op #(.CH(3), .BPC(8), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one input cycle; afterwards the output holds the pixel of the previous call (LAT=2).
    task automatic send(input string tag, input logic vs, input logic av, input logic [23:0] d,
                        input logic [23:0] e, input bit do_chk);
        vif.vsync       = vs;
        vif.activeVideo = av;
        vif.videoData   = d;
        step();
        if (chk_d1) chk(tag_d1, 32'(vif.videoData_out), 32'(exp_d1));
        tag_d1 = tag;
        exp_d1 = e;
        chk_d1 = do_chk;
    endtask

    task automatic frame_start(input logic [1:0] m, input logic [2:0] en, input logic [7:0] thr,
                               input logic av, input logic [23:0] d, input logic [23:0] e);
        vif.mode_in   = m;
        vif.chan_en   = en;
        vif.thresh_in = thr;
        send("vs_px", 1'b1, av, d, e, 1'b1);
        exp_frames++;
    endtask

    task automatic chk_stats(input string tag, input logic [23:0] exp_pix);
`ifdef VIDEO_PIXOP_STATS_EN
        chk({tag, "_pixcnt"}, 32'(vif.pixel_count), 32'(exp_pix));
        chk({tag, "_frmcnt"}, 32'(vif.frame_count), 32'(exp_frames[15:0]));
`else
        chk({tag, "_pixcnt"}, 32'(vif.pixel_count), 32'(exp_pix & 24'h00_0000));
        chk({tag, "_frmcnt"}, 32'(vif.frame_count), 32'h0000_0000);
`endif
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0; exp_frames = 0;
        chk_d1 = 1'b0; exp_d1 = 24'h00_0000; tag_d1 = "none";
        vif.mode_in = 2'b00; vif.chan_en = 3'b111; vif.thresh_in = 8'h80;
        vif.activeVideo = 1'b0; vif.videoData = 24'h00_0000; vif.vsync = 1'b0; vif.hsync = 1'b0;

        // T1: reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vif.mode_in     = 2'($urandom());
            vif.chan_en     = 3'($urandom());
            vif.thresh_in   = 8'($urandom());
            vif.activeVideo = 1'b1;
            vif.videoData   = 24'($urandom());
            vif.vsync       = 1'($urandom());
            vif.hsync       = 1'b1;
            step();
        end
        chk("t1_data",  32'(vif.videoData_out),   32'h0000_0000);
        chk("t1_av",    32'(vif.activeVideo_out), 32'h0000_0000);
        chk("t1_vs",    32'(vif.vsync_out),       32'h0000_0000);
        chk("t1_hs",    32'(vif.hsync_out),       32'h0000_0000);
        chk("t1_mode",  32'(vif.mode_active),     32'h0000_0000);
        chk_stats("t1", 24'h00_0000);
        rst = 1'b0;
        vif.mode_in = 2'b00; vif.chan_en = 3'b111; vif.thresh_in = 8'h80;
        vif.activeVideo = 1'b0; vif.videoData = 24'h00_0000; vif.vsync = 1'b0; vif.hsync = 1'b0;

        // T2: latency and sync alignment in invert mode
        frame_start(2'b01, 3'b111, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        chk("t2_mode", 32'(vif.mode_active), 32'h0000_0001);
        send("t2_inv", 1'b0, 1'b1, 24'h12_3456, 24'hED_CBA9, 1'b1);
        chk("t2_vs_out", 32'(vif.vsync_out), 32'h0000_0001);
        chk("t2_av_early", 32'(vif.activeVideo_out), 32'h0000_0000);
        vif.hsync = 1'b1;
        send("t2_b0", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        chk("t2_av_out", 32'(vif.activeVideo_out), 32'h0000_0001);
        chk("t2_vs_fall", 32'(vif.vsync_out), 32'h0000_0000);
        chk("t2_hs_early", 32'(vif.hsync_out), 32'h0000_0000);
        vif.hsync = 1'b0;
        send("t2_b1", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        chk("t2_hs_out", 32'(vif.hsync_out), 32'h0000_0001);
        chk("t2_av_fall", 32'(vif.activeVideo_out), 32'h0000_0000);
        send("t2_b2", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        chk("t2_hs_fall", 32'(vif.hsync_out), 32'h0000_0000);

        // T3: mid-frame mode change is ignored until the pixel after the next vsync rise
        frame_start(2'b00, 3'b111, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        vif.mode_in = 2'b01;
        send("t3_mid", 1'b0, 1'b1, 24'hA5_5A3C, 24'hA5_5A3C, 1'b1);
        send("t3_b0", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        chk("t3_mode_old", 32'(vif.mode_active), 32'h0000_0000);
        frame_start(2'b01, 3'b111, 8'h80, 1'b1, 24'h11_2233, 24'h11_2233);
        chk("t3_mode_new", 32'(vif.mode_active), 32'h0000_0001);
        send("t3_new", 1'b0, 1'b1, 24'h11_2233, 24'hEE_DDCC, 1'b1);
        send("t3_b1", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);

        // T4: threshold with channel enables, then invert on a single channel
        frame_start(2'b10, 3'b101, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        send("t4_thr_a", 1'b0, 1'b1, 24'h80_7F10, 24'hFF_7F00, 1'b1);
        send("t4_thr_b", 1'b0, 1'b1, 24'h7F_FF81, 24'h00_FFFF, 1'b1);
        send("t4_b0", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        frame_start(2'b01, 3'b010, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        send("t4_inv_en", 1'b0, 1'b1, 24'h12_3456, 24'h12_CB56, 1'b1);
        send("t4_b1", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);

        // T5: grayscale, including a disabled channel that still feeds the sum
        frame_start(2'b11, 3'b111, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        send("t5_white", 1'b0, 1'b1, 24'hFF_FFFF, 24'hFF_FFFF, 1'b1);
        send("t5_green", 1'b0, 1'b1, 24'h00_FF00, 24'h7F_7F7F, 1'b1);
        send("t5_b0", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        frame_start(2'b11, 3'b101, 8'h80, 1'b0, 24'h00_0000, 24'h00_0000);
        send("t5_en101", 1'b0, 1'b1, 24'h00_10FC, 24'h47_1047, 1'b1);
        send("t5_b1", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);

        // Mid-frame reset flushes the pipeline and restores pass mode
        send("rst_pre", 1'b0, 1'b1, 24'h9A_BCDE, 24'h00_0000, 1'b0);
        rst = 1'b1;
        step();
        chk("rst_data", 32'(vif.videoData_out), 32'h0000_0000);
        chk("rst_av", 32'(vif.activeVideo_out), 32'h0000_0000);
        chk("rst_mode", 32'(vif.mode_active), 32'h0000_0000);
        rst = 1'b0;
        exp_frames = 0;
        tag_d1 = "rst_flush"; exp_d1 = 24'h00_0000; chk_d1 = 1'b1;
        send("rst_pass", 1'b0, 1'b1, 24'h9A_BCDE, 24'h9A_BCDE, 1'b1);
        send("rst_b0", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b1);
        chk_stats("rst", 24'h00_0000);

        // T6: 640x2 frame for statistics, blanking with all-ones data
        frame_start(2'b01, 3'b111, 8'h80, 1'b0, 24'hFF_FFFF, 24'h00_0000);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 640; p++) begin
                send("t6_px", 1'b0, 1'b1, 24'(l * 4096 + p), ~24'(l * 4096 + p), 1'b1);
            end
            vif.hsync = 1'b1;
            for (int b = 0; b < 8; b++) begin
                send("t6_blank", 1'b0, 1'b0, 24'hFF_FFFF, 24'h00_0000, 1'b1);
            end
            vif.hsync = 1'b0;
        end
        chk("t6_av_blank", 32'(vif.activeVideo_out), 32'h0000_0000);
        frame_start(2'b01, 3'b111, 8'h80, 1'b0, 24'hFF_FFFF, 24'h00_0000);
        chk_stats("t6_frame", 24'd1280);
        for (int p = 0; p < 5; p++) begin
            send("t6_short", 1'b0, 1'b1, 24'h00_0F0F, 24'hFF_F0F0, 1'b1);
        end
        frame_start(2'b01, 3'b111, 8'h80, 1'b1, 24'h0F_0F0F, 24'hF0_F0F0);
        chk_stats("t6_edge", 24'd6);
        send("t6_end", 1'b0, 1'b0, 24'h00_0000, 24'h00_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
